// File: rtl/reg_file_8x16.sv
// Eight-entry register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
module reg_file_8x16 #(
    parameter int unsigned      WIDTH    = 16,
    parameter bit               ZERO_REG = 1'b1,
    parameter bit               BYPASS   = 1'b1,
    parameter int unsigned      SP_INDEX = 7,
    parameter logic [WIDTH-1:0] SP_RESET = 16'hFFFE
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             WE,
    input  logic [2:0]       WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [2:0]       RA1,
    input  logic [2:0]       RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] R3,
    output logic [WIDTH-1:0] R4,
    output logic [WIDTH-1:0] R5,
    output logic [WIDTH-1:0] R6,
    output logic [WIDTH-1:0] R7
);

    localparam logic [2:0] SpIdx = 3'(SP_INDEX);

    logic [WIDTH-1:0] regs_q [8];
    logic             wr_ok;

    // A write to register 0 is discarded when it is hardwired to zero.
    assign wr_ok = WE && !(ZERO_REG && (WA == 3'd0));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= (3'(i) == SpIdx) ? SP_RESET : '0;
            end
        end else if (wr_ok) begin
            regs_q[WA] <= WD;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [2:0] ra);
        logic [WIDTH-1:0] val;
        val = regs_q[ra];
        if (BYPASS && wr_ok && (WA == ra)) begin
            val = WD;
        end
        if (ZERO_REG && (ra == 3'd0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        RD1 = read_port(RA1);
        RD2 = read_port(RA2);
    end

    // Raw taps feed the downstream 8:1 mux and never see the bypass.
    assign R0 = regs_q[0];
    assign R1 = regs_q[1];
    assign R2 = regs_q[2];
    assign R3 = regs_q[3];
    assign R4 = regs_q[4];
    assign R5 = regs_q[5];
    assign R6 = regs_q[6];
    assign R7 = regs_q[7];

endmodule
